// File: rtl/mem_port_arbiter.sv
// Two-port (fetch / load-store) arbiter onto one single-port SRAM.
// Data wins by default; a fetch denied STARVE_MAX cycles in a row is forced through.
module mem_port_arbiter #(
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_inst_req,
    input  logic [31:0] i_inst_addr,
    output logic        o_inst_addr_ok,
    output logic        o_inst_data_ok,
    output logic [31:0] o_inst_rdata,
    input  logic        i_data_req,
    input  logic        i_data_wr,
    input  logic [3:0]  i_data_wstrb,
    input  logic [31:0] i_data_addr,
    input  logic [31:0] i_data_wdata,
    output logic        o_data_addr_ok,
    output logic        o_data_data_ok,
    output logic [31:0] o_data_rdata,
    output logic        o_sram_en,
    output logic [3:0]  o_sram_we,
    output logic [31:0] o_sram_addr,
    output logic [31:0] o_sram_wdata,
    input  logic [31:0] i_sram_rdata
);

    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_SAT = CW'(STARVE_MAX);

    logic [CW-1:0] r_starve;
    logic          r_resp_valid;
    logic          r_resp_inst;
    logic          r_resp_store;

    logic w_inst_force;
    logic w_inst_gnt;
    logic w_data_gnt;

    // Grants are masked during reset so nothing reaches the SRAM while held.
    assign w_inst_force = i_inst_req && (r_starve == STARVE_SAT);
    assign w_data_gnt   = !reset && i_data_req && !w_inst_force;
    assign w_inst_gnt   = !reset && i_inst_req && !w_data_gnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve     <= '0;
            r_resp_valid <= 1'b0;
            r_resp_inst  <= 1'b0;
            r_resp_store <= 1'b0;
        end else begin
            if (i_inst_req && !w_inst_gnt) begin
                if (r_starve != STARVE_SAT)
                    r_starve <= r_starve + CW'(1);
            end else begin
                r_starve <= '0;
            end
            r_resp_valid <= w_inst_gnt || w_data_gnt;
            r_resp_inst  <= w_inst_gnt;
            r_resp_store <= w_data_gnt && i_data_wr;
        end
    end

    always_comb begin
        o_inst_addr_ok = w_inst_gnt;
        o_data_addr_ok = w_data_gnt;
        o_sram_en      = w_inst_gnt || w_data_gnt;
        o_sram_we      = 4'b0;
        o_sram_addr    = 32'h0;
        o_sram_wdata   = 32'h0;
        if (w_data_gnt) begin
            o_sram_addr  = i_data_addr;
            o_sram_wdata = i_data_wdata;
            if (i_data_wr)
                o_sram_we = i_data_wstrb;
        end else if (w_inst_gnt) begin
            o_sram_addr = i_inst_addr;
        end
    end

    // A response pending across a reset is suppressed here as well as cleared.
    always_comb begin
        o_inst_data_ok = !reset && r_resp_valid && r_resp_inst;
        o_data_data_ok = !reset && r_resp_valid && !r_resp_inst;
        o_inst_rdata   = o_inst_data_ok ? i_sram_rdata : 32'h0;
        o_data_rdata   = (o_data_data_ok && !r_resp_store) ? i_sram_rdata : 32'h0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table for the named scenarios,
// then randomized traffic checked against a behavioural arbitration model.
module tb_mem_port_arbiter;

    localparam int SM = 3;

    logic        clk;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr, sram_wdata, sram_rdata;

    int n_vec = 0;
    int n_err = 0;

    mem_port_arbiter #(.STARVE_MAX(SM)) dut (
        .clk(clk), .reset(reset),
        .i_inst_req(inst_req), .i_inst_addr(inst_addr),
        .o_inst_addr_ok(inst_addr_ok), .o_inst_data_ok(inst_data_ok), .o_inst_rdata(inst_rdata),
        .i_data_req(data_req), .i_data_wr(data_wr), .i_data_wstrb(data_wstrb),
        .i_data_addr(data_addr), .i_data_wdata(data_wdata),
        .o_data_addr_ok(data_addr_ok), .o_data_data_ok(data_data_ok), .o_data_rdata(data_rdata),
        .o_sram_en(sram_en), .o_sram_we(sram_we), .o_sram_addr(sram_addr),
        .o_sram_wdata(sram_wdata), .i_sram_rdata(sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          ireq;
        bit          dreq;
        bit          dwr;
        logic [3:0]  wstrb;
        logic [31:0] iaddr;
        logic [31:0] daddr;
        logic [31:0] wdata;
        logic [31:0] srd;
        bit          e_iaok;
        bit          e_daok;
        bit          e_idok;
        bit          e_ddok;
        logic [3:0]  e_we;
        logic [31:0] e_saddr;
        logic [31:0] e_swd;
        logic [31:0] e_ird;
        logic [31:0] e_drd;
    } vec_t;

    function automatic vec_t v(input bit rst, ireq, dreq, dwr, input logic [3:0] wstrb,
                               input logic [31:0] iaddr, daddr, wdata, srd,
                               input bit eia, eda, eid, edd, input logic [3:0] ewe,
                               input logic [31:0] esa, eswd, eird, edrd);
        vec_t r;
        r.rst = rst; r.ireq = ireq; r.dreq = dreq; r.dwr = dwr; r.wstrb = wstrb;
        r.iaddr = iaddr; r.daddr = daddr; r.wdata = wdata; r.srd = srd;
        r.e_iaok = eia; r.e_daok = eda; r.e_idok = eid; r.e_ddok = edd; r.e_we = ewe;
        r.e_saddr = esa; r.e_swd = eswd; r.e_ird = eird; r.e_drd = edrd;
        return r;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0d: got %h, want %h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input bit rst, ireq, dreq, dwr, input logic [3:0] wstrb,
                         input logic [31:0] iaddr, daddr, wdata, srd);
        @(negedge clk);
        reset = rst; inst_req = ireq; inst_addr = iaddr;
        data_req = dreq; data_wr = dwr; data_wstrb = wstrb;
        data_addr = daddr; data_wdata = wdata; sram_rdata = srd;
        #2;
    endtask

    task automatic check_all(input int idx, input bit eia, eda, eid, edd, input logic [3:0] ewe,
                             input logic [31:0] esa, eswd, eird, edrd);
        chk("inst_addr_ok", idx, {31'b0, inst_addr_ok}, {31'b0, eia});
        chk("data_addr_ok", idx, {31'b0, data_addr_ok}, {31'b0, eda});
        chk("inst_data_ok", idx, {31'b0, inst_data_ok}, {31'b0, eid});
        chk("data_data_ok", idx, {31'b0, data_data_ok}, {31'b0, edd});
        chk("sram_en",      idx, {31'b0, sram_en}, {31'b0, eia | eda});
        chk("sram_we",      idx, {28'b0, sram_we}, {28'b0, ewe});
        chk("sram_addr",    idx, sram_addr, esa);
        chk("sram_wdata",   idx, sram_wdata, eswd);
        chk("inst_rdata",   idx, inst_rdata, eird);
        chk("data_rdata",   idx, data_rdata, edrd);
        chk("one_data_ok",  idx, {31'b0, inst_data_ok & data_data_ok}, 32'h0);
    endtask

    localparam logic [31:0] IA = 32'h1c00_0008;
    localparam logic [31:0] DA = 32'h0000_3000;

    vec_t tbl[$];

    // behavioural model state: cycles of unbroken fetch denial, and the one access in flight
    int m_denied;
    bit m_pend, m_pend_inst, m_pend_store;

    initial begin
        reset = 1'b1; inst_req = 0; inst_addr = 0; data_req = 0; data_wr = 0;
        data_wstrb = 0; data_addr = 0; data_wdata = 0; sram_rdata = 0;
        repeat (3) @(posedge clk);

        // rst ireq dreq dwr wstrb iaddr daddr wdata srd | iaok daok idok ddok we saddr swd ird drd
        tbl.push_back(v(1,1,1,0,4'h0, IA, DA, 32'h0, 32'h0,  0,0,0,0,4'h0, 0, 0, 0, 0));
        tbl.push_back(v(0,1,0,0,4'h0, 32'h1c000000, 0, 0, 32'h0,  1,0,0,0,4'h0, 32'h1c000000, 0, 0, 0));
        tbl.push_back(v(0,0,0,0,4'h0, 0, 0, 0, 32'h02800421,  0,0,1,0,4'h0, 0, 0, 32'h02800421, 0));
        tbl.push_back(v(0,0,1,1,4'hF, 0, 32'h1000, 32'hDEADBEEF, 32'h0,  0,1,0,0,4'hF, 32'h1000, 32'hDEADBEEF, 0, 0));
        tbl.push_back(v(0,0,0,0,4'h0, 0, 0, 0, 32'h12345678,  0,0,0,1,4'h0, 0, 0, 0, 0));
        tbl.push_back(v(0,0,1,0,4'h3, 0, 32'h2000, 32'h55, 32'h0,  0,1,0,0,4'h0, 32'h2000, 32'h55, 0, 0));
        tbl.push_back(v(0,1,0,0,4'h0, 32'h1c000004, 0, 0, 32'hAAAA0001,  1,0,0,1,4'h0, 32'h1c000004, 0, 0, 32'hAAAA0001));
        tbl.push_back(v(0,0,0,0,4'h0, 0, 0, 0, 32'hBBBB0002,  0,0,1,0,4'h0, 0, 0, 32'hBBBB0002, 0));
        // sustained contention: 3 data, 1 inst, data again
        tbl.push_back(v(0,1,1,0,4'h0, IA, DA, 0, 32'hC0,  0,1,0,0,4'h0, DA, 0, 0, 0));
        tbl.push_back(v(0,1,1,0,4'h0, IA, DA, 0, 32'hC1,  0,1,0,1,4'h0, DA, 0, 0, 32'hC1));
        tbl.push_back(v(0,1,1,0,4'h0, IA, DA, 0, 32'hC2,  0,1,0,1,4'h0, DA, 0, 0, 32'hC2));
        tbl.push_back(v(0,1,1,0,4'h0, IA, DA, 0, 32'hC3,  1,0,0,1,4'h0, IA, 0, 0, 32'hC3));
        tbl.push_back(v(0,1,1,0,4'h0, IA, DA, 0, 32'hC4,  0,1,1,0,4'h0, DA, 0, 32'hC4, 0));
        tbl.push_back(v(0,1,1,0,4'h0, IA, DA, 0, 32'hC5,  0,1,0,1,4'h0, DA, 0, 0, 32'hC5));
        // fetch drops with count at 2: three fresh denials needed again
        tbl.push_back(v(0,0,1,0,4'h0, IA, DA, 0, 32'hC6,  0,1,0,1,4'h0, DA, 0, 0, 32'hC6));
        tbl.push_back(v(0,1,1,0,4'h0, IA, DA, 0, 32'hC7,  0,1,0,1,4'h0, DA, 0, 0, 32'hC7));
        tbl.push_back(v(0,1,1,0,4'h0, IA, DA, 0, 32'hC8,  0,1,0,1,4'h0, DA, 0, 0, 32'hC8));
        tbl.push_back(v(0,1,1,0,4'h0, IA, DA, 0, 32'hC9,  0,1,0,1,4'h0, DA, 0, 0, 32'hC9));
        tbl.push_back(v(0,1,1,0,4'h0, IA, DA, 0, 32'hCA,  1,0,0,1,4'h0, IA, 0, 0, 32'hCA));
        tbl.push_back(v(0,0,0,0,4'h0, IA, DA, 0, 32'hCB,  0,0,1,0,4'h0, 0, 0, 32'hCB, 0));
        // reset right after a load grant drops the response
        tbl.push_back(v(0,0,1,0,4'h0, 0, 32'h4000, 0, 32'hD0,  0,1,0,0,4'h0, 32'h4000, 0, 0, 0));
        tbl.push_back(v(1,1,1,1,4'hF, IA, DA, 32'h77, 32'hD1,  0,0,0,0,4'h0, 0, 0, 0, 0));
        tbl.push_back(v(0,1,0,0,4'h0, 32'h1c000010, 0, 0, 32'hD2,  1,0,0,0,4'h0, 32'h1c000010, 0, 0, 0));
        tbl.push_back(v(0,0,0,0,4'h0, 0, 0, 0, 32'hD3,  0,0,1,0,4'h0, 0, 0, 32'hD3, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].ireq, tbl[i].dreq, tbl[i].dwr, tbl[i].wstrb,
                  tbl[i].iaddr, tbl[i].daddr, tbl[i].wdata, tbl[i].srd);
            check_all(i, tbl[i].e_iaok, tbl[i].e_daok, tbl[i].e_idok, tbl[i].e_ddok,
                      tbl[i].e_we, tbl[i].e_saddr, tbl[i].e_swd, tbl[i].e_ird, tbl[i].e_drd);
        end

        // randomized traffic, starting from a reset cycle so the model is aligned
        m_denied = 0; m_pend = 0; m_pend_inst = 0; m_pend_store = 0;
        for (int c = 0; c < 3000; c++) begin
            bit rst, ireq, dreq, dwr, iw, dw, eid, edd;
            logic [3:0]  wstrb, ewe;
            logic [31:0] iaddr, daddr, wdata, srd, esa, eswd;
            rst   = (c == 0) || ($urandom_range(0, 63) == 0);
            ireq  = ($urandom_range(0, 3) != 0);
            dreq  = ($urandom_range(0, 3) != 0);
            dwr   = $urandom_range(0, 1) == 1;
            wstrb = 4'($urandom);
            iaddr = $urandom; daddr = $urandom; wdata = $urandom; srd = $urandom;
            drive(rst, ireq, dreq, dwr, wstrb, iaddr, daddr, wdata, srd);
            if (rst) begin
                check_all(1000 + c, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
                m_denied = 0; m_pend = 0;
            end else begin
                iw   = ireq && (!dreq || m_denied >= SM);
                dw   = dreq && !iw;
                ewe  = (dw && dwr) ? wstrb : 4'h0;
                esa  = iw ? iaddr : (dw ? daddr : 32'h0);
                eswd = dw ? wdata : 32'h0;
                eid  = m_pend && m_pend_inst;
                edd  = m_pend && !m_pend_inst;
                check_all(1000 + c, iw, dw, eid, edd, ewe, esa, eswd,
                          eid ? srd : 32'h0, (edd && !m_pend_store) ? srd : 32'h0);
                m_denied     = (ireq && !iw) ? ((m_denied + 1 > SM) ? SM : m_denied + 1) : 0;
                m_pend       = iw || dw;
                m_pend_inst  = iw;
                m_pend_store = dw && dwr;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: STARVE_MAX, default 3, consecutive denied inst-request cycles before instruction port is forced ahead of data port.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 inst_req  input  1  fetch request valid.
REQ-005 inst_addr  input  32  fetch byte address.
REQ-006 inst_addr_ok  output  1  fetch request accepted this cycle.
REQ-007 inst_data_ok  output  1  fetch response valid this cycle.
REQ-008 inst_rdata  output  32  fetch response data.
REQ-009 data_req  input  1  load/store request valid.
REQ-010 data_wr  input  1  1 = store, 0 = load.
REQ-011 data_wstrb  input  4  byte write strobes (stores only).
REQ-012 data_addr  input  32  load/store byte address.
REQ-013 data_wdata  input  32  store data.
REQ-014 data_addr_ok  output  1  load/store request accepted this cycle.
REQ-015 data_data_ok  output  1  load/store response valid this cycle (stores included).
REQ-016 data_rdata  output  32  load response data.
REQ-017 sram_en  output  1  shared single-port SRAM enable.
REQ-018 sram_we  output  4  shared SRAM byte write enables.
REQ-019 sram_addr  output  32  shared SRAM address.
REQ-020 sram_wdata  output  32  shared SRAM write data.
REQ-021 sram_rdata  input  32  SRAM read data, valid one cycle after sram_en.

Function
REQ-022 At most one grant per cycle; grant = corresponding *_addr_ok high.
REQ-023 Default priority: data port over instruction port.
REQ-024 Starve counter (width ceil(log2(STARVE_MAX+1))): increments, saturating at STARVE_MAX, each cycle inst_req=1 and inst not granted; clears on inst grant or inst_req=0.
REQ-025 When starve counter == STARVE_MAX and inst_req=1, instruction port wins regardless of data_req.
REQ-026 addr_ok outputs combinational from current req inputs and starve counter; no addr_ok without matching req.
REQ-027 Granted request drives SRAM same cycle: sram_en=1; sram_addr = granted addr; sram_we = data_wstrb if data store grant, else 4'b0; sram_wdata = data_wdata on data grant, else 0.
REQ-028 No grant: sram_en=0, sram_we=0, sram_addr=0, sram_wdata=0.
REQ-029 Response registers resp_valid and resp_owner (inst/data) record each grant; response asserted exactly one cycle after grant.
REQ-030 inst_data_ok = resp_valid & owner=inst; data_data_ok = resp_valid & owner=data; only one *_data_ok high per cycle.
REQ-031 inst_rdata and data_rdata both driven from sram_rdata when respective data_ok high, 0 otherwise; store response rdata = 0.
REQ-032 Back-to-back: new grant permitted in the same cycle a previous response returns; sustained throughput one access per cycle.
REQ-033 Requester holds req/addr/data stable until addr_ok; arbiter does not latch request fields.

Reset
REQ-034 During reset: all addr_ok, data_ok, sram_en, sram_we low; rdata outputs 0; resp_valid=0; starve counter=0.
REQ-035 Reset asserted while response pending: response dropped, no data_ok in cycle after reset deasserts.
REQ-036 First grant possible in first cycle after reset deasserts.

Verification
REQ-037 inst_req only, addr 0x1c000000, sram_rdata=0x02800421 next cycle -> inst_addr_ok cycle N, sram_en=1 sram_we=0, inst_data_ok cycle N+1 with inst_rdata=0x02800421.
REQ-038 Both req every cycle, STARVE_MAX=3 -> data granted cycles 0-2, inst granted cycle 3, counter cleared, data granted cycle 4; pattern repeats.
REQ-039 Store data_wr=1 wstrb=4'hF addr 0x1000 wdata 0xDEADBEEF -> sram_we=4'hF, sram_wdata=0xDEADBEEF cycle N; data_data_ok=1, data_rdata=0 cycle N+1.
REQ-040 Load grant cycle N, inst grant cycle N+1 -> data_data_ok N+1, inst_data_ok N+2, never both same cycle.
REQ-041 Reset asserted cycle after grant -> no data_ok observed; outputs at reset values; fresh inst_req granted first cycle after release.
REQ-042 inst_req drops during starvation count at 2 -> counter cleared; next contention requires 3 fresh denied cycles.
